// File: rtl/ibex_fetch_fifo_pkg.sv
// Shared types and constants for the instruction fetch FIFO.
// Entry layout, depth derivation and the compressed-opcode test.
package ibex_fetch_fifo_pkg;

    localparam logic [1:0] OPCODE_C_MASK = 2'b11;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        valid;
    } fifo_entry_t;

    function automatic int fifo_depth(input int num_reqs);
        return num_reqs + 1;
    endfunction

    function automatic logic is_compressed(input logic [1:0] op);
        return (op & OPCODE_C_MASK) != OPCODE_C_MASK;
    endfunction

endpackage

// File: rtl/ibex_fetch_fifo_if.sv
// Bus-response input and IF-stage output bundle of the fetch FIFO.
// master: prefetch controller / IF side, slave: the FIFO itself.
interface ibex_fetch_fifo_if #(
    parameter int NUM_REQS = 2
);
    logic                clear_i;
    logic [NUM_REQS-1:0] busy_o;
    logic                in_valid_i;
    logic [31:0]         in_addr_i;
    logic [31:0]         in_rdata_i;
    logic                in_err_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [31:0]         out_rdata_o;
    logic [31:0]         out_addr_o;
    logic                out_err_o;
    logic                out_err_plus2_o;

    modport master (
        output clear_i, in_valid_i, in_addr_i,
        output in_rdata_i, in_err_i, out_ready_i,
        input  busy_o, out_valid_o, out_rdata_o,
        input  out_addr_o, out_err_o, out_err_plus2_o
    );

    modport slave (
        input  clear_i, in_valid_i, in_addr_i,
        input  in_rdata_i, in_err_i, out_ready_i,
        output busy_o, out_valid_o, out_rdata_o,
        output out_addr_o, out_err_o, out_err_plus2_o
    );

endinterface

// File: rtl/ibex_fetch_fifo.sv
// Instruction fetch FIFO: stores bus words, realigns them into
// 16/32-bit instructions and hands one per cycle to the IF stage.
module ibex_fetch_fifo
    import ibex_fetch_fifo_pkg::*;
#(
    parameter int NUM_REQS = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ibex_fetch_fifo_if.slave  bus
);

    localparam int DEPTH = fifo_depth(NUM_REQS);

    fifo_entry_t r_entries [DEPTH];
    logic [31:0] r_pc;

    fifo_entry_t w_in;
    fifo_entry_t w_head;
    fifo_entry_t w_ext [DEPTH+1];
    fifo_entry_t w_next [DEPTH];
    logic        w_sec_valid;
    logic        w_sec_err;
    logic [15:0] w_sec_lo;
    logic        w_unaligned;
    logic        w_comp;
    logic        w_wide;
    logic        w_head_err;
    logic        w_valid;
    logic        w_err;
    logic        w_accept;
    logic        w_inc4;
    logic        w_pop;
    logic        w_push;
    logic [NUM_REQS-1:0] w_busy;

    assign w_in = {bus.in_rdata_i, bus.in_err_i, bus.in_valid_i};

    // Head and second word, bypassing the incoming word into empty slots
    always_comb begin
        w_head      = r_entries[0].valid ? r_entries[0] : w_in;
        w_sec_valid = r_entries[1].valid
                    | (r_entries[0].valid & bus.in_valid_i);
        w_sec_err   = 1'b0;
        w_sec_lo    = '0;
        if (r_entries[1].valid) begin
            w_sec_err = r_entries[1].err;
            w_sec_lo  = r_entries[1].rdata[15:0];
        end else if (r_entries[0].valid && bus.in_valid_i) begin
            w_sec_err = bus.in_err_i;
            w_sec_lo  = bus.in_rdata_i[15:0];
        end
    end

    assign w_unaligned = r_pc[1];
    assign w_comp      = w_unaligned ? is_compressed(w_head.rdata[17:16])
                                     : is_compressed(w_head.rdata[1:0]);
    assign w_wide      = w_unaligned & ~w_comp;
    assign w_head_err  = w_head.valid & w_head.err;
    assign w_valid     = w_head.valid & (~w_wide | w_sec_valid | w_head.err);
    assign w_err       = w_head_err | (w_wide & w_sec_err);

    assign w_accept = w_valid & bus.out_ready_i & ~bus.clear_i;
    assign w_inc4   = ~w_comp | w_err;
    assign w_pop    = w_accept & (w_unaligned | w_inc4);
    assign w_push   = bus.in_valid_i & ~bus.clear_i;

    // Stored words followed by the incoming one, then shifted by the pop
    always_comb begin
        logic prev_valid;
        prev_valid = 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
            if (r_entries[j].valid) begin
                w_ext[j] = r_entries[j];
            end else if (w_push && prev_valid) begin
                w_ext[j] = w_in;
            end else begin
                w_ext[j] = '0;
            end
            prev_valid = r_entries[j].valid;
        end
        w_ext[DEPTH] = (w_push && prev_valid) ? w_in : '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_next[i] = w_pop ? w_ext[i+1] : w_ext[i];
        end
    end

    // Occupancy of the upper entries, from registered state only
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            w_busy[i] = r_entries[DEPTH-NUM_REQS+i].valid;
        end
    end

    // Entry storage and PC update
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_pc <= '0;
        end else if (bus.clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_pc <= bus.in_addr_i & 32'hFFFF_FFFE;
        end else begin
            r_entries <= w_next;
            if (w_accept) begin
                r_pc <= r_pc + (w_inc4 ? 32'd4 : 32'd2);
            end
        end
    end

    assign bus.busy_o          = w_busy;
    assign bus.out_valid_o     = w_valid;
    assign bus.out_addr_o      = r_pc;
    assign bus.out_err_o       = w_err;
    assign bus.out_err_plus2_o = w_wide & ~w_head_err & w_sec_err;
    assign bus.out_rdata_o     = w_unaligned
                               ? {w_sec_lo, w_head.rdata[31:16]}
                               : w_head.rdata;

    no_overflow: assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(w_push && r_entries[DEPTH-1].valid && !w_pop)
    );

endmodule

// File: tb/tb_ibex_fetch_fifo.sv
// Self-checking bench for ibex_fetch_fifo.
// Directed scenarios plus random traffic against a halfword-stream model.
module tb_ibex_fetch_fifo;

    localparam int NUM_REQS = 2;
    localparam int DEPTH    = NUM_REQS + 1;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    ibex_fetch_fifo_if #(.NUM_REQS(NUM_REQS)) bus ();

    ibex_fetch_fifo #(.NUM_REQS(NUM_REQS)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic clr, input logic [31:0] addr,
                         input logic v, input logic [31:0] d,
                         input logic e, input logic rdy);
        bus.clear_i     = clr;
        bus.in_addr_i   = addr;
        bus.in_valid_i  = v;
        bus.in_rdata_i  = d;
        bus.in_err_i    = e;
        bus.out_ready_i = rdy;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #2;
        n_checks += 4;
        if (bus.out_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_valid got %b exp 0", bus.out_valid_o);
        end
        if (bus.busy_o !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_busy got %b exp 00", bus.busy_o);
        end
        if (bus.out_addr_o !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_addr got %h exp 0", bus.out_addr_o);
        end
        if ({bus.out_err_o, bus.out_err_plus2_o} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_err got %b%b exp 00",
                     bus.out_err_o, bus.out_err_plus2_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_bypass();
        @(negedge clk);
        drive(1, 32'h80, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 1, 32'h0000_0013, 0, 1);
        #2;
        n_checks += 3;
        if (bus.out_valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL bypass_valid got %b exp 1", bus.out_valid_o);
        end
        if (bus.out_addr_o !== 32'h80) begin
            n_errors++;
            $display("FAIL bypass_addr got %h exp 80", bus.out_addr_o);
        end
        if (bus.out_rdata_o !== 32'h0000_0013) begin
            n_errors++;
            $display("FAIL bypass_rdata got %h exp 13", bus.out_rdata_o);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        n_checks += 3;
        if (bus.out_addr_o !== 32'h84) begin
            n_errors++;
            $display("FAIL bypass_pc got %h exp 84", bus.out_addr_o);
        end
        if (bus.out_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL bypass_empty got %b exp 0", bus.out_valid_o);
        end
        if (bus.busy_o !== 2'b00) begin
            n_errors++;
            $display("FAIL bypass_busy got %b exp 00", bus.busy_o);
        end
    endtask

    task automatic test_compressed_pair();
        @(negedge clk);
        drive(1, 32'h80, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 1, 32'h4501_4505, 0, 1);
        #2;
        n_checks += 2;
        if (bus.out_addr_o !== 32'h80) begin
            n_errors++;
            $display("FAIL cpair_addr0 got %h exp 80", bus.out_addr_o);
        end
        if (bus.out_valid_o !== 1'b1
            || bus.out_rdata_o[15:0] !== 16'h4505) begin
            n_errors++;
            $display("FAIL cpair_data0 got %b/%h exp 1/4505",
                     bus.out_valid_o, bus.out_rdata_o[15:0]);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1);
        #2;
        n_checks += 2;
        if (bus.out_addr_o !== 32'h82) begin
            n_errors++;
            $display("FAIL cpair_addr1 got %h exp 82", bus.out_addr_o);
        end
        if (bus.out_valid_o !== 1'b1
            || bus.out_rdata_o[15:0] !== 16'h4501) begin
            n_errors++;
            $display("FAIL cpair_data1 got %b/%h exp 1/4501",
                     bus.out_valid_o, bus.out_rdata_o[15:0]);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1);
        #2;
        n_checks += 1;
        if (bus.out_valid_o !== 1'b0 || bus.out_addr_o !== 32'h84) begin
            n_errors++;
            $display("FAIL cpair_pop got %b/%h exp 0/84",
                     bus.out_valid_o, bus.out_addr_o);
        end
    endtask

    task automatic test_unaligned();
        @(negedge clk);
        drive(1, 32'h82, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 1, 32'h0093_0000, 0, 1);
        #2;
        n_checks += 1;
        if (bus.out_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL unal_wait got %b exp 0", bus.out_valid_o);
        end
        @(negedge clk);
        drive(0, 0, 1, 32'h0000_0000, 0, 1);
        #2;
        n_checks += 2;
        if (bus.out_valid_o !== 1'b1 || bus.out_addr_o !== 32'h82) begin
            n_errors++;
            $display("FAIL unal_valid got %b/%h exp 1/82",
                     bus.out_valid_o, bus.out_addr_o);
        end
        if (bus.out_rdata_o !== 32'h0000_0093) begin
            n_errors++;
            $display("FAIL unal_rdata got %h exp 93", bus.out_rdata_o);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        n_checks += 1;
        if (bus.out_addr_o !== 32'h86 || bus.out_valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL unal_next got %h/%b exp 86/1",
                     bus.out_addr_o, bus.out_valid_o);
        end
    endtask

    task automatic test_errors();
        @(negedge clk);
        drive(1, 32'h82, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 1, 32'h0093_0000, 0, 0);
        @(negedge clk);
        drive(0, 0, 1, 32'h0000_0000, 1, 0);
        #2;
        n_checks += 1;
        if ({bus.out_valid_o, bus.out_err_o, bus.out_err_plus2_o}
            !== 3'b111) begin
            n_errors++;
            $display("FAIL err_second got %b%b%b exp 111", bus.out_valid_o,
                     bus.out_err_o, bus.out_err_plus2_o);
        end
        @(negedge clk);
        drive(1, 32'h82, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 1, 32'h0093_0000, 1, 0);
        #2;
        n_checks += 1;
        if ({bus.out_valid_o, bus.out_err_o, bus.out_err_plus2_o}
            !== 3'b110) begin
            n_errors++;
            $display("FAIL err_head got %b%b%b exp 110", bus.out_valid_o,
                     bus.out_err_o, bus.out_err_plus2_o);
        end
    endtask

    task automatic test_busy_clear();
        @(negedge clk);
        drive(1, 32'h0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(0, 0, 1, 32'h0000_0013, 0, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        n_checks += 1;
        if (bus.busy_o !== 2'b11 || bus.out_valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL busy_full got %b/%b exp 11/1",
                     bus.busy_o, bus.out_valid_o);
        end
        @(negedge clk);
        drive(1, 32'h40, 1, 32'h0000_0013, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        n_checks += 2;
        if (bus.busy_o !== 2'b00 || bus.out_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL busy_clear got %b/%b exp 00/0",
                     bus.busy_o, bus.out_valid_o);
        end
        if (bus.out_addr_o !== 32'h40) begin
            n_errors++;
            $display("FAIL clear_pc got %h exp 40", bus.out_addr_o);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(1, 32'h100, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(0, 0, 1, 32'h0000_0013, 0, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        n_checks += 1;
        if (bus.out_valid_o !== 1'b1 || bus.busy_o !== 2'b01) begin
            n_errors++;
            $display("FAIL arst_pre got %b/%b exp 1/01",
                     bus.out_valid_o, bus.busy_o);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks += 2;
        if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 2'b00) begin
            n_errors++;
            $display("FAIL arst_drop got %b/%b exp 0/00",
                     bus.out_valid_o, bus.busy_o);
        end
        if (bus.out_addr_o !== 32'h0) begin
            n_errors++;
            $display("FAIL arst_pc got %h exp 0", bus.out_addr_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        word_t       mq[$];
        word_t       a[$];
        logic [15:0] h[$];
        logic [31:0] m_pc;
        logic [31:0] addr;
        logic [31:0] d;
        logic        clr, v, e, rdy;
        logic        ev, elong, eerr, ep2;
        logic [NUM_REQS-1:0] ebusy;
        int          st, n;

        m_pc = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            clr  = ($urandom_range(0, 39) == 0);
            v    = !clr && (mq.size() < DEPTH)
                 && ($urandom_range(0, 2) != 0);
            d    = $urandom;
            e    = ($urandom_range(0, 11) == 0);
            rdy  = ($urandom_range(0, 3) != 0);
            addr = ($urandom_range(0, 2) == 0)
                 ? 32'hFFFF_FFF8 + ($urandom & 32'h6) : $urandom;
            @(negedge clk);
            drive(clr, addr, v, d, e, rdy);
            #2;

            a = mq;
            if (v) a.push_back('{d: d, e: e});
            h.delete();
            foreach (a[k]) begin
                h.push_back(a[k].d[15:0]);
                h.push_back(a[k].d[31:16]);
            end
            st    = int'(m_pc[1]);
            ev    = 1'b0;
            elong = 1'b0;
            eerr  = 1'b0;
            ep2   = 1'b0;
            if (h.size() > st) begin
                elong = (h[st][1:0] == 2'b11);
                if (a[0].e) begin
                    ev   = 1'b1;
                    eerr = 1'b1;
                end else if (!elong) begin
                    ev = 1'b1;
                end else if (h.size() > st + 1) begin
                    ev   = 1'b1;
                    eerr = a[(st+1)/2].e;
                    ep2  = eerr;
                end
            end
            for (int i = 0; i < NUM_REQS; i++) begin
                ebusy[i] = mq.size() > (DEPTH - NUM_REQS + i);
            end

            n_checks += 3;
            if (bus.out_valid_o !== ev) begin
                n_errors++;
                $display("FAIL rnd_valid cyc %0d got %b exp %b",
                         cyc, bus.out_valid_o, ev);
            end
            if (bus.out_addr_o !== m_pc) begin
                n_errors++;
                $display("FAIL rnd_addr cyc %0d got %h exp %h",
                         cyc, bus.out_addr_o, m_pc);
            end
            if (bus.busy_o !== ebusy) begin
                n_errors++;
                $display("FAIL rnd_busy cyc %0d got %b exp %b",
                         cyc, bus.busy_o, ebusy);
            end
            if (ev) begin
                n_checks += 3;
                if ({bus.out_err_o, bus.out_err_plus2_o} !== {eerr, ep2})
                begin
                    n_errors++;
                    $display("FAIL rnd_err cyc %0d got %b%b exp %b%b", cyc,
                             bus.out_err_o, bus.out_err_plus2_o, eerr, ep2);
                end
                if (bus.out_rdata_o[15:0] !== h[st]) begin
                    n_errors++;
                    $display("FAIL rnd_lo cyc %0d got %h exp %h",
                             cyc, bus.out_rdata_o[15:0], h[st]);
                end
                if (elong && h.size() > st + 1
                    && bus.out_rdata_o[31:16] !== h[st+1]) begin
                    n_errors++;
                    $display("FAIL rnd_hi cyc %0d got %h exp %h",
                             cyc, bus.out_rdata_o[31:16], h[st+1]);
                end
            end

            if (clr) begin
                mq.delete();
                m_pc = addr & 32'hFFFF_FFFE;
            end else begin
                if (v) mq.push_back('{d: d, e: e});
                if (ev && rdy) begin
                    n = (elong || eerr) ? 2 : 1;
                    m_pc = m_pc + 32'(2 * n);
                    for (int k = 0; k < (st + n) / 2; k++) begin
                        void'(mq.pop_front());
                    end
                end
            end
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        test_reset();
        test_bypass();
        test_compressed_pair();
        test_unaligned();
        test_errors();
        test_busy_clear();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
